// File: rtl/fifo_flags.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_flags
//  Purpose  : Single-clock show-ahead FIFO with occupancy count, programmable
//             almost-full/almost-empty flags, sticky errors and sync flush.
//  Revision : 1.0
// ============================================================================
module fifo_flags #(
    parameter int B        = 8,
    parameter int W        = 4,
    parameter int AF_LEVEL = 2**W - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam int       DEPTH   = 2**W;
    localparam logic [W:0] c_DEPTH = (W+1)'(DEPTH);
    localparam logic [W:0] c_AF    = (W+1)'(AF_LEVEL);
    localparam logic [W:0] c_AE    = (W+1)'(AE_LEVEL);
    localparam logic [W:0] c_ONE   = (W+1)'(1);

    logic [B-1:0] r_mem [DEPTH];
    logic [W-1:0] r_wptr;
    logic [W-1:0] r_rptr;
    logic [W:0]   r_count;
    logic         r_full;
    logic         r_empty;
    logic         r_almost_full;
    logic         r_almost_empty;
    logic         r_overflow;
    logic         r_underflow;

    logic         w_wr_acc;
    logic         w_rd_acc;
    logic [W:0]   w_count_next;

    // A full FIFO still accepts a write when the same cycle pops a word.
    assign w_wr_acc = wr && (!r_full || rd);
    assign w_rd_acc = rd && !r_empty;

    always_comb begin
        w_count_next = r_count;
        if (clr)
            w_count_next = '0;
        else if (w_wr_acc && !w_rd_acc)
            w_count_next = r_count + c_ONE;
        else if (!w_wr_acc && w_rd_acc)
            w_count_next = r_count - c_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_count        <= w_count_next;
            r_full         <= (w_count_next == c_DEPTH);
            r_empty        <= (w_count_next == '0);
            r_almost_full  <= (w_count_next >= c_AF);
            r_almost_empty <= (w_count_next <= c_AE);
            if (clr) begin
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (w_wr_acc)
                    r_wptr <= r_wptr + 1'b1;
                if (w_rd_acc)
                    r_rptr <= r_rptr + 1'b1;
                if (wr && r_full && !rd)
                    r_overflow <= 1'b1;
                if (rd && r_empty)
                    r_underflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!clr && w_wr_acc)
            r_mem[r_wptr] <= w_data;
    end

    assign r_data       = r_mem[r_rptr];
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: doc/fifo_flags.md
# fifo_flags

Parametrised synchronous FIFO that replaces the basic UART FIFO in the receive and transmit paths. It adds:
- an occupancy count and programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags;
- a synchronous flush;
- correct simultaneous read/write handling at the empty and full boundaries.

It is a single-clock buffer between the UART rx/tx engines and the host-side interface.

## Interface
- B, 8, data word width in bits
- W, 4, address bits; depth = 2**W words
- AF_LEVEL, 2**W-2, almost_full asserts when count >= AF_LEVEL (legal 1..2**W)
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (legal 0..2**W-1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- clr  in  1  synchronous flush, active-high
- wr  in  1  write request
- rd  in  1  read request (pop)
- w_data  in  B  write data
- r_data  out  B  head-of-queue word (show-ahead)
- full  out  1  count == 2**W
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  W+1  words currently stored, 0..2**W
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: 2**W x B register array; write pointer, read pointer (W bits, natural wrap 2**W-1 -> 0), count register (W+1 bits).
- Accepted write: wr && (!full || rd). Writes w_data at w_ptr; w_ptr+1.
- Accepted read: rd && !empty. r_ptr+1.
- Count: +1 on write-only accept, -1 on read-only accept, unchanged when both or neither are accepted.
- wr && rd when empty:
  - write accepted, read ignored;
  - count 0 -> 1;
  - underflow set.
- wr && rd when full:
  - both accepted;
  - count stays 2**W;
  - full stays 1;
  - overflow not set.
- wr when full and !rd: data dropped, pointers unchanged, overflow set.
- rd when empty and !wr: pointers unchanged, underflow set.
- clr:
  - pointers and count go to 0;
  - overflow/underflow cleared;
  - wr/rd in the same cycle ignored (clr has priority).
- Flags:
  - full, empty, almost_full and almost_empty are registered;
  - each is computed from count_next, so it always agrees with count.
- r_data = array[r_ptr] combinationally. It is valid only while empty==0. Contents are not reset.

## Timing
- Reset values:
  - count = 0;
  - w_ptr = r_ptr = 0;
  - empty = 1, full = 0;
  - almost_empty = 1 (AE_LEVEL >= 0);
  - almost_full = 0;
  - overflow = underflow = 0.
- All flag and count changes are visible on the clock edge that accepts the operation; there are no extra cycles.
- Write-to-read latency is 1 cycle:
  - after the edge that writes into an empty FIFO, empty = 0 and r_data shows that word;
  - rd may pop it in that same following cycle.
- Pop: r_data advances to the next word on the edge that accepts rd.
- Reset mid-operation:
  - asynchronously forces all reset values;
  - the first operation is honoured on the first rising edge after reset deasserts.
- Sticky errors stay set until reset or clr.

## Test plan
All scenarios use B=8, W=2 (depth 4), AF_LEVEL=3, AE_LEVEL=1.
1. Fill and drain:
   - write 0xA1..0xA4 -> after the 4th edge, count=4, full=1, almost_full=1 (set from count 3 onward);
   - 4 reads return 0xA1..0xA4 in order, then empty=1, almost_empty=1.
2. Overflow:
   - with the FIFO full, write 0x55 -> count stays 4, overflow=1, no data corruption;
   - subsequent reads return 0xA1..0xA4.
3. Simultaneous read/write on empty: wr=rd=1 with 0x3C -> count=1, empty=0, r_data=0x3C, underflow=1.
4. Simultaneous read/write on full: wr=rd=1 with 0x77 -> count=4, r_data advances, overflow=0; after 3 further reads, r_data=0x77.
5. Wrap-around: 10 interleaved write/read pairs -> pointers wrap, data order preserved, count never exceeds 1.
6. Flush and reset:
   - clr with count=3 and wr=1 -> count=0, empty=1, sticky flags cleared, written word discarded;
   - asserting reset mid-write -> immediate reset values.
